// File: rtl/dpb_pkg.sv
// Shared constants, pointer type and read-latency selection for the dual-port byte buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a. Macro DPB_RD_OREG_EN selects the registered BRAM output (LAT=2, SD=3).
package dpb_pkg;

    localparam int DPB_AW    = 11;
    localparam int DPB_DW    = 8;
    localparam int DPB_DEPTH = 2048;

`ifdef DPB_RD_OREG_EN
    localparam int DPB_LAT = 2;
`else
    localparam int DPB_LAT = 1;
`endif
    // One skid slot per read that can be in flight, plus the head being presented.
    localparam int DPB_SD = DPB_LAT + 1;

    // Buffer pointer: low bits address the RAM, MSB is the wrap bit.
    typedef logic [DPB_AW:0] dpb_ptr_t;

    // Fill level between two pointers; the wrap bit makes full and empty distinguishable.
    function automatic dpb_ptr_t ptr_diff(input dpb_ptr_t a, input dpb_ptr_t b);
        return a - b;
    endfunction

endpackage

// File: rtl/dpb_skid_fifo.sv
// Small register FIFO that absorbs BRAM read returns while the stream is stalled.
// Latency: push visible at head one cycle later; head is a register.
// Backpressure: none internally; the caller never pushes without a free slot (pop frees one the same cycle).
module dpb_skid_fifo #(
    parameter int DW = 8,
    parameter int SD = 2,
    parameter int CW = $clog2(SD + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [CW-1:0] count,
    output logic [DW-1:0] head
);

    logic [DW-1:0] mem_q [SD];
    logic [DW-1:0] mem_d [SD];
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] wr_idx;

    // Shift-down on pop, then write the new entry behind the surviving ones so a
    // push into a single-entry FIFO that is popping lands straight in the head.
    always_comb begin
        for (int i = 0; i < SD; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (pop) begin
            for (int i = 0; i < SD - 1; i++) begin
                mem_d[i] = mem_q[i + 1];
            end
        end
        wr_idx = cnt_q - CW'(pop);
        if (push) begin
            for (int i = 0; i < SD; i++) begin
                if (wr_idx == CW'(i)) begin
                    mem_d[i] = din;
                end
            end
        end
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        if (clear) begin
            cnt_d = '0;
        end
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SD; i++) begin
                mem_q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < SD; i++) begin
                mem_q[i] <= mem_d[i];
            end
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
    assign head  = mem_q[0];

endmodule

// File: rtl/dpb_rd_stream.sv
// Drain side of the 2048x8 dual-port byte buffer: issues BRAM port-B reads and streams bytes out.
// Latency: LAT+1 cycles from wr_ptr advance to m_tvalid (LAT=1, or 2 with DPB_RD_OREG_EN); 1 byte/cycle sustained.
// Backpressure: m_tready low holds m_tdata; reads issue only while a skid slot is guaranteed.
module dpb_rd_stream
    import dpb_pkg::*;
#(
    parameter int AW = DPB_AW,
    parameter int DW = DPB_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW:0]   wr_ptr,
    output logic [AW:0]   rd_ptr,
    input  logic          flush,
    output logic [AW-1:0] bram_adb,
    output logic          bram_ceb,
    output logic          bram_oceb,
    input  logic [DW-1:0] bram_doutb,
    output logic [DW-1:0] m_tdata,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic          empty
);

    localparam int LAT = DPB_LAT;
    localparam int SD  = DPB_SD;
    localparam int CW  = $clog2(SD + 1);

    logic [AW:0]    iss_ptr;
    logic [AW:0]    rd_ptr_q;
    logic [LAT-1:0] pipe_q;
    logic [LAT-1:0] pipe_d;
    logic [CW-1:0]  skid_cnt;
    logic           pop;
    logic           has_unread;
    logic           issue;
    int             inflight;
    int             occ;

    assign pop        = m_tvalid & m_tready;
    assign has_unread = (iss_ptr != wr_ptr);

    // Issue a read only when its return is guaranteed a skid slot, counting the pop this cycle.
    always_comb begin
        inflight = $countones(pipe_q);
        occ      = int'(skid_cnt) + inflight - int'(pop);
        issue    = rst_n & ~flush & has_unread & (occ < SD);
    end

    assign bram_ceb = issue;
    assign bram_adb = iss_ptr[AW-1:0];

`ifdef DPB_RD_OREG_EN
    // Advance the BRAM output register only when stage 1 holds a live read.
    assign bram_oceb = pipe_q[0];
`else
    assign bram_oceb = 1'b1;
`endif

    // Valid tags follow each read down the BRAM pipeline; the last stage marks returning data.
    always_comb begin
        pipe_d    = '0;
        pipe_d[0] = issue;
        for (int i = 1; i < LAT; i++) begin
            pipe_d[i] = pipe_q[i - 1];
        end
    end

    // Issue/release pointers and pipeline tags; flush resynchronises to the writer and kills in-flight reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_ptr  <= '0;
            rd_ptr_q <= '0;
            pipe_q   <= '0;
        end else if (flush) begin
            iss_ptr  <= wr_ptr;
            rd_ptr_q <= wr_ptr;
            pipe_q   <= '0;
        end else begin
            pipe_q <= pipe_d;
            if (issue) begin
                iss_ptr <= iss_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    dpb_skid_fifo #(
        .DW (DW),
        .SD (SD),
        .CW (CW)
    ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush),
        .push  (pipe_q[LAT-1]),
        .din   (bram_doutb),
        .pop   (pop & ~flush),
        .count (skid_cnt),
        .head  (m_tdata)
    );

    assign m_tvalid = (skid_cnt != '0);
    assign rd_ptr   = rd_ptr_q;
    assign empty    = ~has_unread & ~m_tvalid & (pipe_q == '0);

endmodule

// File: tb/tb_dpb_rd_stream.sv
module tb_dpb_rd_stream;
    import dpb_pkg::*;

    localparam int AW  = DPB_AW;
    localparam int DW  = DPB_DW;
    localparam int LAT = DPB_LAT;
    localparam int SD  = DPB_SD;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          flush;
    logic [AW-1:0] bram_adb;
    logic          bram_ceb;
    logic          bram_oceb;
    logic [DW-1:0] bram_doutb;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          empty;

    always #5 clk = ~clk;

    dpb_rd_stream dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_ptr     (wr_ptr),
        .rd_ptr     (rd_ptr),
        .flush      (flush),
        .bram_adb   (bram_adb),
        .bram_ceb   (bram_ceb),
        .bram_oceb  (bram_oceb),
        .bram_doutb (bram_doutb),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .empty      (empty)
    );

    // BRAM port B model: read stage, optional output register.
    logic [DW-1:0] mem [DPB_DEPTH];
    logic [DW-1:0] st1;
    logic [DW-1:0] dout_r;

    always @(posedge clk) begin
        if (bram_ceb) st1 <= mem[bram_adb];
        if (bram_oceb) dout_r <= st1;
    end
    assign bram_doutb = (LAT == 2) ? dout_r : st1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int occ, over_issue, stall_bad, acc_cnt, first_vld;
    bit stalled_prev;
    logic [DW-1:0] held;
    logic [DW-1:0] got[$];
    logic [AW-1:0] adr[$];
    int hs_cyc[$];

    task automatic clear_mon();
        got.delete();
        adr.delete();
        hs_cyc.delete();
        acc_cnt = 0;
        occ = 0;
        first_vld = -1;
        stalled_prev = 0;
        over_issue = 0;
        stall_bad = 0;
    endtask

    // One clock: observe at negedge, return 1 time unit after the next posedge.
    task automatic tick();
        bit hs;
        @(negedge clk);
        cyc++;
        hs = m_tvalid && m_tready;
        if (stalled_prev && (!m_tvalid || m_tdata !== held)) stall_bad++;
        stalled_prev = m_tvalid && !m_tready;
        held = m_tdata;
        if (m_tvalid && first_vld < 0) first_vld = cyc;
        if (bram_ceb) begin
            adr.push_back(bram_adb);
            if (occ - int'(hs) >= SD) over_issue++;
            occ++;
        end
        if (hs) begin
            got.push_back(m_tdata);
            hs_cyc.push_back(cyc);
            acc_cnt++;
            occ--;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int start, input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) mem[(start + i) % DPB_DEPTH] = DW'(base + i);
        wr_ptr = (AW+1)'(start + n);
    endtask

    task automatic run_until(input int n, input int budget);
        int k = 0;
        while (acc_cnt < n && k < budget) begin
            tick();
            k++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_ptr = '0; flush = 1'b0; m_tready = 1'b0;
        #3;
        checks++; if (rd_ptr !== '0) begin errors++; $display("FAIL reset_rd_ptr: got %0h expected 0", rd_ptr); end
        checks++; if (bram_ceb !== 1'b0) begin errors++; $display("FAIL reset_ceb: got %b expected 0", bram_ceb); end
        checks++; if (bram_adb !== '0) begin errors++; $display("FAIL reset_adb: got %0h expected 0", bram_adb); end
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", m_tvalid); end
        checks++; if (m_tdata !== '0) begin errors++; $display("FAIL reset_tdata: got %0h expected 0", m_tdata); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_stream();
        int cyc0;
        clear_mon();
        m_tready = 1'b1;
        cyc0 = cyc;
        load(0, 16, 8'h00);
        run_until(16, 100);
        tick();
        checks++; if (first_vld - cyc0 - 1 !== LAT + 1) begin errors++; $display("FAIL stream_latency: got %0d expected %0d", first_vld - cyc0 - 1, LAT + 1); end
        checks++; if (acc_cnt !== 16) begin errors++; $display("FAIL stream_count: got %0d expected 16", acc_cnt); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (i >= got.size() || got[i] !== DW'(i)) begin
                errors++; $display("FAIL stream_data[%0d]: got %0h expected %0h", i, (i < got.size()) ? got[i] : 8'hxx, i);
            end
        end
        checks++;
        if (hs_cyc.size() < 16 || hs_cyc[15] - hs_cyc[0] !== 15) begin
            errors++; $display("FAIL stream_gapless: got %0d handshakes spanning %0d expected 16 spanning 15", hs_cyc.size(), (hs_cyc.size() > 0) ? hs_cyc[hs_cyc.size()-1] - hs_cyc[0] : -1);
        end
        checks++; if (rd_ptr !== 12'd16) begin errors++; $display("FAIL stream_rd_ptr: got %0d expected 16", rd_ptr); end
        checks++; if (empty !== 1'b1 || m_tvalid !== 1'b0) begin errors++; $display("FAIL stream_idle: got empty=%b tvalid=%b expected 1 0", empty, m_tvalid); end
    endtask

    task automatic test_backpressure();
        bit pat [12] = '{1, 0, 0, 1, 1, 0, 1, 0, 0, 1, 1, 1};
        int k = 0;
        clear_mon();
        load(16, 16, 8'h40);
        while (acc_cnt < 16 && k < 200) begin
            m_tready = pat[k % 12];
            tick();
            k++;
        end
        m_tready = 1'b1;
        tick();
        tick();
        checks++; if (acc_cnt !== 16) begin errors++; $display("FAIL bp_count: got %0d expected 16", acc_cnt); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (i >= got.size() || got[i] !== DW'(8'h40 + i)) begin
                errors++; $display("FAIL bp_data[%0d]: got %0h expected %0h", i, (i < got.size()) ? got[i] : 8'hxx, 8'h40 + i);
            end
        end
        checks++; if (stall_bad !== 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stall cycles expected 0", stall_bad); end
        checks++; if (over_issue !== 0) begin errors++; $display("FAIL bp_no_overissue: got %0d reads without slot expected 0", over_issue); end
        checks++; if (rd_ptr !== 12'd32) begin errors++; $display("FAIL bp_rd_ptr: got %0d expected 32", rd_ptr); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL bp_empty: got %b expected 1", empty); end
    endtask

    task automatic test_wrap();
        wr_ptr = 12'd2040;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (rd_ptr !== 12'd2040) begin errors++; $display("FAIL wrap_start: got %0d expected 2040", rd_ptr); end
        clear_mon();
        m_tready = 1'b1;
        load(2040, 16, 8'hA0);
        run_until(16, 100);
        tick();
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (i >= adr.size() || adr[i] !== AW'((2040 + i) % DPB_DEPTH)) begin
                errors++; $display("FAIL wrap_addr[%0d]: got %0d expected %0d", i, (i < adr.size()) ? adr[i] : 11'hx, (2040 + i) % DPB_DEPTH);
            end
            checks++;
            if (i >= got.size() || got[i] !== DW'(8'hA0 + i)) begin
                errors++; $display("FAIL wrap_data[%0d]: got %0h expected %0h", i, (i < got.size()) ? got[i] : 8'hxx, 8'hA0 + i);
            end
        end
        checks++; if (rd_ptr !== 12'd2056) begin errors++; $display("FAIL wrap_rd_ptr: got %0d expected 2056", rd_ptr); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b expected 1", empty); end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; wr_ptr = '0; flush = 1'b0; m_tready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        clear_mon();
    endtask

    task automatic test_flush();
        int n_at_flush;
        do_reset();
        m_tready = 1'b1;
        load(0, 8, 8'h60);
        run_until(3, 50);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= got.size() || got[i] !== DW'(8'h60 + i)) begin
                errors++; $display("FAIL flush_pre_data[%0d]: got %0h expected %0h", i, (i < got.size()) ? got[i] : 8'hxx, 8'h60 + i);
            end
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_at_flush = acc_cnt;
        occ = 0;
        stalled_prev = 0;
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL flush_tvalid: got %b expected 0", m_tvalid); end
        checks++; if (rd_ptr !== 12'd8) begin errors++; $display("FAIL flush_rd_ptr: got %0d expected 8", rd_ptr); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty: got %b expected 1", empty); end
        for (int i = 0; i < 6; i++) tick();
        checks++; if (acc_cnt !== n_at_flush) begin errors++; $display("FAIL flush_no_stale: got %0d bytes expected %0d", acc_cnt, n_at_flush); end
        load(8, 2, 8'hC0);
        run_until(n_at_flush + 2, 30);
        tick();
        checks++;
        if (got.size() != n_at_flush + 2 || got[n_at_flush] !== 8'hC0 || got[n_at_flush + 1] !== 8'hC1) begin
            errors++; $display("FAIL flush_resume: got %0d bytes expected %0d with C0 C1", got.size(), n_at_flush + 2);
        end
        checks++; if (rd_ptr !== 12'd10) begin errors++; $display("FAIL flush_resume_ptr: got %0d expected 10", rd_ptr); end
    endtask

    task automatic test_reset_midstream();
        int k = 0;
        clear_mon();
        m_tready = 1'b0;
        load(10, 4, 8'h80);
        while (!m_tvalid && k < 10) begin
            tick();
            k++;
        end
        checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b expected 1", m_tvalid); end
        #2;
        rst_n = 1'b0;
        wr_ptr = '0;
        #1;
        checks++;
        if (m_tvalid !== 1'b0 || m_tdata !== '0 || rd_ptr !== '0 || bram_ceb !== 1'b0 || bram_adb !== '0 || empty !== 1'b1) begin
            errors++; $display("FAIL mid_reset: got tvalid=%b tdata=%0h rd_ptr=%0d ceb=%b adb=%0d empty=%b expected 0 0 0 0 0 1", m_tvalid, m_tdata, rd_ptr, bram_ceb, bram_adb, empty);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        clear_mon();
        m_tready = 1'b1;
        load(0, 4, 8'h90);
        run_until(4, 40);
        tick();
        checks++; if (adr.size() < 1 || adr[0] !== '0) begin errors++; $display("FAIL mid_addr0: got %0d reads first %0d expected first 0", adr.size(), (adr.size() > 0) ? adr[0] : 11'hx); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= got.size() || got[i] !== DW'(8'h90 + i)) begin
                errors++; $display("FAIL mid_data[%0d]: got %0h expected %0h", i, (i < got.size()) ? got[i] : 8'hxx, 8'h90 + i);
            end
        end
        checks++; if (acc_cnt !== 4 || rd_ptr !== 12'd4) begin errors++; $display("FAIL mid_count: got %0d bytes rd_ptr %0d expected 4 4", acc_cnt, rd_ptr); end
    endtask

    initial begin
        for (int i = 0; i < DPB_DEPTH; i++) mem[i] = '0;
        clear_mon();
        test_reset();
        test_stream();
        test_backpressure();
        test_wrap();
        test_flush();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
